// File: rtl/freq_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : freq_div_pkg
// Description : Shared defaults and helpers for the sawtooth frequency divider.
//               - FD_WIDTH / FD_DIV_RATIO / FD_STEP : default parameter values
//               - fd_cnt_width()                    : prescaler count width
// Revision    : 1.0 - initial release
// ============================================================================
package freq_div_pkg;

    localparam int FD_WIDTH     = 8;
    localparam int FD_DIV_RATIO = 4;
    localparam int FD_STEP      = 1;

    // Width of a counter that runs 0..ratio-1. A ratio of 1 still needs a
    // one-bit register so the count type is never zero-width.
    function automatic int fd_cnt_width(input int ratio);
        int w;
        w = $clog2(ratio);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : freq_div_pkg
`default_nettype wire

// File: rtl/freq_div_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : freq_div_prescaler
// Description : Clock-enable prescaler. Counts 0..DIV_RATIO-1 and raises
//               tick_en (combinational, from the registered count) during
//               the cycle whose rising edge is an update edge.
// Ports       : clk     - system clock, rising edge
//               rst_n   - synchronous active-low reset
//               tick_en - update enable for the current cycle
// Revision    : 1.0 - initial release
// ============================================================================
module freq_div_prescaler
    import freq_div_pkg::*;
#(
    parameter int DIV_RATIO = FD_DIV_RATIO
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_en
);

    localparam int               CNT_W    = fd_cnt_width(DIV_RATIO);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_RATIO - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // With DIV_RATIO=1 the count is pinned at 0 == CNT_LAST, so every
    // cycle is an update cycle.
    always_comb begin
        tick_en = (count_q == CNT_LAST);
        count_d = tick_en ? '0 : (count_q + CNT_ONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule : freq_div_prescaler
`default_nettype wire

// File: rtl/frequency_divider.sv
`default_nettype none
// ============================================================================
// Module      : frequency_divider
// Description : Digital sawtooth generator. A prescaler produces an update
//               enable every DIV_RATIO clocks; each update advances the ramp
//               by STEP, wrapping to 0 once another step would pass PEAK.
// Ports       : clk           - system clock, rising edge
//               rst_n         - synchronous active-low reset
//               SawTooth_wave - registered unsigned ramp sample
//               div_tick      - one-cycle pulse when the sample changes
//               wrap          - one-cycle pulse when the sample wraps to 0
// Revision    : 1.0 - initial release
// ============================================================================
module frequency_divider
    import freq_div_pkg::*;
#(
    parameter int WIDTH     = FD_WIDTH,
    parameter int DIV_RATIO = FD_DIV_RATIO,
    parameter int STEP      = FD_STEP,
    parameter int PEAK      = (2 ** WIDTH) - 1
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] SawTooth_wave,
    output logic             div_tick,
    output logic             wrap
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter legality
    // ------------------------------------------------------------------
    if (DIV_RATIO < 1) begin : g_chk_div_ratio
        $error("frequency_divider: DIV_RATIO must be >= 1");
    end
    if (STEP < 1) begin : g_chk_step_min
        $error("frequency_divider: STEP must be >= 1");
    end
    if (STEP > PEAK) begin : g_chk_step_max
        $error("frequency_divider: STEP must not exceed PEAK");
    end
    if ((PEAK < 1) || (longint'(PEAK) > ((longint'(1) << WIDTH) - 1))) begin : g_chk_peak
        $error("frequency_divider: PEAK must be in 1..2**WIDTH-1");
    end

    // Comparing against PEAK-STEP before adding keeps the sum within PEAK,
    // so the adder can never overflow WIDTH bits.
    localparam logic [WIDTH-1:0] WRAP_ABOVE = WIDTH'(PEAK - STEP);
    localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);

    logic tick_en;

    freq_div_prescaler #(
        .DIV_RATIO (DIV_RATIO)
    ) u_prescaler (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick_en (tick_en)
    );

    logic [WIDTH-1:0] wave_q;
    logic [WIDTH-1:0] wave_d;
    logic             div_tick_q;
    logic             div_tick_d;
    logic             wrap_q;
    logic             wrap_d;

    always_comb begin
        wave_d     = wave_q;
        div_tick_d = tick_en;
        wrap_d     = 1'b0;
        if (tick_en) begin
            if (wave_q > WRAP_ABOVE) begin
                // Restart at 0; any remainder below PEAK is discarded.
                wave_d = '0;
                wrap_d = 1'b1;
            end else begin
                wave_d = wave_q + STEP_W;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wave_q     <= '0;
            div_tick_q <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            wave_q     <= wave_d;
            div_tick_q <= div_tick_d;
            wrap_q     <= wrap_d;
        end
    end

    assign SawTooth_wave = wave_q;
    assign div_tick      = div_tick_q;
    assign wrap          = wrap_q;

endmodule : frequency_divider
`default_nettype wire

// File: tb/tb_frequency_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_frequency_divider
// Description : Self-checking bench for frequency_divider. Three instances:
//               A - defaults (WIDTH 8, DIV 4, STEP 1, PEAK 255)
//               B - DIV 1, STEP 16, PEAK 255
//               C - DIV 2, STEP 7,  PEAK 20
//               Expected outputs come from the number of edges since reset
//               release, using the ramp arithmetic directly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frequency_divider;

    logic       clk;
    logic       rst_a;
    logic       rst_bc;
    logic [7:0] wave_a, wave_b, wave_c;
    logic       tick_a, tick_b, tick_c;
    logic       wrap_a, wrap_b, wrap_c;

    int checks;
    int errors;

    // Edges seen with reset deasserted since the last reset edge.
    int n_a;
    int n_bc;
    bit started;

    frequency_divider u_dut_a (
        .clk           (clk),
        .rst_n         (rst_a),
        .SawTooth_wave (wave_a),
        .div_tick      (tick_a),
        .wrap          (wrap_a)
    );

    frequency_divider #(
        .WIDTH     (8),
        .DIV_RATIO (1),
        .STEP      (16),
        .PEAK      (255)
    ) u_dut_b (
        .clk           (clk),
        .rst_n         (rst_bc),
        .SawTooth_wave (wave_b),
        .div_tick      (tick_b),
        .wrap          (wrap_b)
    );

    frequency_divider #(
        .WIDTH     (8),
        .DIV_RATIO (2),
        .STEP      (7),
        .PEAK      (20)
    ) u_dut_c (
        .clk           (clk),
        .rst_n         (rst_bc),
        .SawTooth_wave (wave_c),
        .div_tick      (tick_c),
        .wrap          (wrap_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        n_a  <= rst_a  ? n_a + 1  : 0;
        n_bc <= rst_bc ? n_bc + 1 : 0;
        if (!rst_a && !rst_bc) started <= 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // After n edges out of reset: u = n/div updates have happened, the ramp
    // has floor(peak/step)+1 distinct values, and it shows (u mod that)*step.
    function automatic void model(input int n, input int div, input int step, input int peak,
                                  output int w, output bit t, output bit wr);
        int u;
        u  = n / div;
        t  = (n > 0) && (n % div == 0);
        w  = (u % (peak / step + 1)) * step;
        wr = t && (w == 0);
    endfunction

    // Per-cycle comparison against the model, plus literal pins.
    always @(negedge clk) begin
        int  w;
        bit  t, wr;
        if (started) begin
            model(n_a, 4, 1, 255, w, t, wr);
            chk("A_wave", {24'd0, wave_a}, w);
            chk("A_tick", {31'd0, tick_a}, {31'd0, t});
            chk("A_wrap", {31'd0, wrap_a}, {31'd0, wr});

            model(n_bc, 1, 16, 255, w, t, wr);
            chk("B_wave", {24'd0, wave_b}, w);
            chk("B_tick", {31'd0, tick_b}, {31'd0, t});
            chk("B_wrap", {31'd0, wrap_b}, {31'd0, wr});

            model(n_bc, 2, 7, 20, w, t, wr);
            chk("C_wave", {24'd0, wave_c}, w);
            chk("C_tick", {31'd0, tick_c}, {31'd0, t});
            chk("C_wrap", {31'd0, wrap_c}, {31'd0, wr});
            chk("C_le_peak", {31'd0, (wave_c <= 8'd20)}, 32'd1);

            // Hand-computed anchors
            if (n_a == 4)    chk("A_lit_first", {24'd0, wave_a}, 32'd1);
            if (n_a == 8)    chk("A_lit_second", {24'd0, wave_a}, 32'd2);
            if (n_a >= 1020 && n_a <= 1023) chk("A_lit_hold255", {24'd0, wave_a}, 32'd255);
            if (n_a == 1024 || n_a == 2048) begin
                chk("A_lit_wrap_val", {24'd0, wave_a}, 32'd0);
                chk("A_lit_wrap", {31'd0, wrap_a}, 32'd1);
                chk("A_lit_wrap_tick", {31'd0, tick_a}, 32'd1);
            end
            if (n_a == 1025) chk("A_lit_wrap_1cyc", {31'd0, wrap_a}, 32'd0);
            if (n_bc == 15)  chk("B_lit_240", {24'd0, wave_b}, 32'd240);
            if (n_bc == 16)  chk("B_lit_wrap", {31'd0, wrap_b}, 32'd1);
            if (n_bc == 2)   chk("C_lit_7", {24'd0, wave_c}, 32'd7);
            if (n_bc == 4)   chk("C_lit_14", {24'd0, wave_c}, 32'd14);
            if (n_bc == 5)   chk("C_lit_14_hold", {24'd0, wave_c}, 32'd14);
            if (n_bc == 6) begin
                chk("C_lit_wrap_val", {24'd0, wave_c}, 32'd0);
                chk("C_lit_wrap", {31'd0, wrap_c}, 32'd1);
            end
        end
    end

    initial begin
        int i;
        checks  = 0;
        errors  = 0;
        started = 1'b0;
        n_a     = 0;
        n_bc    = 0;
        rst_a   = 1'b0;
        rst_bc  = 1'b0;

        // Hold reset for 3 edges, checking the reset state.
        repeat (3) begin
            @(negedge clk);
            chk("rst_A_wave", {24'd0, wave_a}, 32'd0);
            chk("rst_A_tick", {31'd0, tick_a}, 32'd0);
            chk("rst_A_wrap", {31'd0, wrap_a}, 32'd0);
        end
        rst_a  = 1'b1;
        rst_bc = 1'b1;

        // Run through two full default periods into the third, then stop
        // where the ramp shows 100 with the prescaler count at 2.
        for (i = 0; i < 5000 && n_a != 2450; i++) @(negedge clk);
        chk("A_reach_mid", n_a, 32'd2450);
        chk("A_mid_val100", {24'd0, wave_a}, 32'd100);

        rst_a = 1'b0;
        @(negedge clk);
        chk("A_mid_rst_val", {24'd0, wave_a}, 32'd0);
        chk("A_mid_rst_tick", {31'd0, tick_a}, 32'd0);
        rst_a = 1'b1;
        repeat (3) @(negedge clk);
        chk("A_post_rst3", {24'd0, wave_a}, 32'd0);
        @(negedge clk);
        chk("A_post_rst4_val", {24'd0, wave_a}, 32'd1);
        chk("A_post_rst4_tick", {31'd0, tick_a}, 32'd1);

        repeat (1100) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_frequency_divider
`default_nettype wire

// File: doc/frequency_divider.md
Name: frequency_divider

Overview:
- Digital sawtooth generator. A clock-enable prescaler divides `clk` by `DIV_RATIO`, and each enable pulse advances an up-counting ramp by `STEP`.
- The ramp wraps to 0 after reaching `PEAK`.
- The output `SawTooth_wave` is a registered unsigned sample intended to feed a DAC or a downstream waveform consumer.
- Single clock domain, no inputs other than clock and reset.

Parameters:
- `WIDTH`, default 8: width of `SawTooth_wave` in bits.
- `DIV_RATIO`, default 4: number of `clk` cycles per ramp update. Legal range is ≥1; 1 means update every cycle.
- `STEP`, default 1: increment added to the ramp on each update. Legal range is 1..`PEAK`.
- `PEAK`, default 2**`WIDTH`-1: maximum ramp value before wrap. Legal range is 1..2**`WIDTH`-1.

Ports:
- `clk`  input  1  system clock; all logic on rising edge.
- `rst_n`  input  1  synchronous active-low reset.
- `SawTooth_wave`  output  `WIDTH`  registered ramp sample, unsigned.
- `div_tick`  output  1  registered one-cycle pulse, high in the cycle in which `SawTooth_wave` takes a new value.
- `wrap`  output  1  registered one-cycle pulse, high in the cycle in which `SawTooth_wave` becomes 0 by wrap-around.

Behaviour:
- **Reset:** one clock; reset is synchronous and active-low, sampled on rising `clk`. While `rst_n`=0 at an edge:
  - prescaler count ← 0
  - `SawTooth_wave` ← 0
  - `div_tick` ← 0
  - `wrap` ← 0
- Reset asserted mid-ramp takes effect at the next edge. No partial state survives.
- **Prescaler:** a count of width clog2(`DIV_RATIO`), minimum 1 bit.
  - On each edge out of reset, if count == `DIV_RATIO`-1, then count ← 0 and an update occurs. Otherwise count ← count+1.
  - With `DIV_RATIO`=1 every edge is an update.
- **Ramp update:** evaluated on an update edge.
  - If `SawTooth_wave` > `PEAK`-`STEP`: `SawTooth_wave` ← 0 and `wrap` ← 1.
  - Otherwise: `SawTooth_wave` ← `SawTooth_wave`+`STEP` and `wrap` ← 0.
  - The comparison is done before the add, so the sum never exceeds `PEAK` and never overflows `WIDTH`.
  - The ramp is not saturating: it always restarts at 0, with no carry-over of remainder.
- **Pulse outputs:**
  - `div_tick` ← 1 on an update edge, else 0.
  - `wrap` ← 0 on non-update edges.
- **Latency after reset release:** the first edge with `rst_n`=1 is edge 1. The first update occurs at edge `DIV_RATIO`, and updates then repeat every `DIV_RATIO` edges.
- **Period:** ramp period = `DIV_RATIO` × (floor(`PEAK`/`STEP`)+1) clk cycles. With defaults this is 4×256 = 1024 cycles.
- **Output stability:** `SawTooth_wave` holds its value between updates. All outputs are glitch-free flops.
- **Parameter checks:** an elaboration-time check fails the build if `DIV_RATIO`<1, `STEP`<1, `STEP`>`PEAK`, or `PEAK`>2**`WIDTH`-1.
- **Synthesis:** no latches; no gated or derived clocks. The divider produces an enable, never a clock.

Decomposition:
- Shared package `freq_div_pkg` holds:
  - default constants `FD_WIDTH`=8, `FD_DIV_RATIO`=4, `FD_STEP`=1
  - a function computing the prescaler count width (clog2, minimum 1)
- One sub-module, `freq_div_prescaler`:
  - parameter `DIV_RATIO`
  - ports `clk`, `rst_n`, `tick_en`
  - produces the combinational update enable from its registered count
- The top level contains the ramp register and the pulse flops.

Test Plan:
1. **Reset and first update (defaults):** hold `rst_n`=0 for 3 edges, then release.
   - `SawTooth_wave`=0, `div_tick`=0, `wrap`=0 during reset.
   - `SawTooth_wave` becomes 1 with `div_tick`=1 after edge 4 post-release, becomes 2 after edge 8, and so on.
2. **Full wrap (defaults):** run 1024+ cycles.
   - Value 255 is held for 4 cycles, then becomes 0 with `wrap`=1 and `div_tick`=1 for exactly one cycle.
   - The next period is again 1024 cycles.
3. **Mid-ramp reset:** assert `rst_n`=0 for one edge while `SawTooth_wave`=100 and the prescaler count is 2.
   - Next cycle `SawTooth_wave`=0.
   - The next update is 4 edges after release, to value 1.
4. **DIV_RATIO=1, STEP=16, PEAK=255:**
   - The sequence 0,16,…,240 changes every cycle, then goes to 0 with `wrap`=1.
   - Period 16 cycles; `div_tick` stays high continuously.
5. **Non-aligned step (STEP=7, PEAK=20, DIV_RATIO=2):**
   - Sequence 0,7,14 then wrap to 0 (since 14 > 13), each value held 2 cycles.
   - Period 6 cycles; `SawTooth_wave` is never above 20.
6. **Illegal parameters:** `STEP`=0 or `DIV_RATIO`=0 fails elaboration.
